// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the IF/MEM single-port memory arbiter.
package mem_arb_pkg;

    localparam int unsigned DEF_ADDR_W     = 32;
    localparam int unsigned DEF_DATA_W     = 32;
    localparam int unsigned DEF_STARVE_LIM = 4;
    localparam int unsigned PERF_W         = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_DATA = 1'b0,
        OWN_INST = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, memory and stall signals of the arbiter; slave = arbiter view, master = pipeline/memory view.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = mem_arb_pkg::DEF_ADDR_W,
    parameter int unsigned DATA_W = mem_arb_pkg::DEF_DATA_W
);
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              stall_f;
    logic              stall_m;

    modport slave (
        input  d_req, d_we, d_addr, d_wdata, i_req, i_addr, mem_ready, mem_rvalid, mem_rdata,
        output d_gnt, d_rvalid, d_rdata, i_gnt, i_rvalid, i_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, stall_f, stall_m
    );

    modport master (
        output d_req, d_we, d_addr, d_wdata, i_req, i_addr, mem_ready, mem_rvalid, mem_rdata,
        input  d_gnt, d_rvalid, d_rdata, i_gnt, i_rvalid, i_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, stall_f, stall_m
    );

endinterface

// File: rtl/mem_arb_select.sv
// Fixed data-first winner selection with a saturating streak counter that guarantees fetch progress.
module mem_arb_select #(
    parameter int unsigned STARVE_LIM = mem_arb_pkg::DEF_STARVE_LIM
) (
    input  logic clk,
    input  logic rst,
    input  logic d_req_i,
    input  logic i_req_i,
    input  logic grant_i,
    output logic win_inst_c
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIM + 1);
    localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

    logic [CNT_W-1:0] streak_q, streak_d;

    assign win_inst_c = i_req_i & (~d_req_i | (streak_q == LIM));

    // Streak counts data wins taken while fetch was waiting.
    always_comb begin
        streak_d = streak_q;
        if (grant_i) begin
            if (win_inst_c || !i_req_i) begin
                streak_d = '0;
            end else if (streak_q != LIM) begin
                streak_d = streak_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and data, with pipeline stalls.
// Optional ARB_PERF_CNT_EN adds conflict/stall performance counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned STARVE_LIM = DEF_STARVE_LIM
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0]   perf_conflict_cnt,
    output logic [PERF_W-1:0]   perf_stall_cnt
`endif
);

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              d_gnt_q, d_gnt_d, i_gnt_q, i_gnt_d;
    logic              d_rvalid_q, d_rvalid_d, i_rvalid_q, i_rvalid_d;
    logic              mem_req_q, mem_req_d;
    logic              any_req_c, grant_c, win_inst_c, stall_f_c;

    assign any_req_c = bus.d_req | bus.i_req;
    assign grant_c   = (state_q == ST_IDLE) & any_req_c;

    mem_arb_select #(.STARVE_LIM(STARVE_LIM)) u_select (
        .clk        (clk),
        .rst        (rst),
        .d_req_i    (bus.d_req),
        .i_req_i    (bus.i_req),
        .grant_i    (grant_c),
        .win_inst_c (win_inst_c)
    );

    // Next state plus next values of every registered output.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        d_gnt_d    = 1'b0;
        i_gnt_d    = 1'b0;
        d_rvalid_d = 1'b0;
        i_rvalid_d = 1'b0;
        mem_req_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req_c) begin
                    state_d   = ST_REQ;
                    owner_d   = win_inst_c ? OWN_INST : OWN_DATA;
                    we_d      = win_inst_c ? 1'b0 : bus.d_we;
                    addr_d    = win_inst_c ? bus.i_addr : bus.d_addr;
                    wdata_d   = win_inst_c ? '0 : bus.d_wdata;
                    mem_req_d = 1'b1;
                    d_gnt_d   = ~win_inst_c;
                    i_gnt_d   = win_inst_c;
                end
            end
            ST_REQ: begin
                if (bus.mem_ready) begin
                    state_d = ST_WAIT;
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (bus.mem_rvalid) begin
                    state_d    = ST_DONE;
                    rdata_d    = bus.mem_rdata;
                    d_rvalid_d = (owner_q == OWN_DATA);
                    i_rvalid_d = (owner_q == OWN_INST);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_DATA;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            d_gnt_q    <= 1'b0;
            i_gnt_q    <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_rvalid_q <= 1'b0;
            mem_req_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            d_gnt_q    <= d_gnt_d;
            i_gnt_q    <= i_gnt_d;
            d_rvalid_q <= d_rvalid_d;
            i_rvalid_q <= i_rvalid_d;
            mem_req_q  <= mem_req_d;
        end
    end

    assign stall_f_c     = bus.i_req & ~i_rvalid_q;
    assign bus.stall_f   = stall_f_c;
    assign bus.stall_m   = bus.d_req & ~d_rvalid_q;
    assign bus.d_gnt     = d_gnt_q;
    assign bus.i_gnt     = i_gnt_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.i_rvalid  = i_rvalid_q;
    assign bus.d_rdata   = rdata_q;
    assign bus.i_rdata   = rdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

`ifdef ARB_PERF_CNT_EN
    logic [PERF_W-1:0] conflict_q, stall_q;

    // Free-running, wrapping event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_q <= '0;
            stall_q    <= '0;
        end else begin
            if ((state_q == ST_IDLE) && bus.d_req && bus.i_req) begin
                conflict_q <= conflict_q + PERF_W'(1);
            end
            if (stall_f_c) begin
                stall_q <= stall_q + PERF_W'(1);
            end
        end
    end

    assign perf_conflict_cnt = conflict_q;
    assign perf_stall_cnt    = stall_q;
`endif

endmodule
